// File: rtl/m_axi_burst_sequencer.sv
// rtl/m_axi_burst_sequencer.sv - AXI4 master write/read-back burst sequencer
// Optional read-back and compare phase: `M_AXI_READ_CHECK_EN
module m_axi_burst_sequencer #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_M_AXI_BURST_LEN          = 16,
    parameter int          C_NUM_BURSTS               = 4
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] BASE   = C_M_TARGET_SLAVE_BASE_ADDR[AW-1:0];
    localparam logic [AW-1:0] STRIDE = AW'(C_M_AXI_BURST_LEN * 4);
    localparam logic [7:0]    AXLEN  = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [8:0]    LAST_K = 9'(C_M_AXI_BURST_LEN - 1);
    localparam logic [5:0]    LAST_B = 6'(C_NUM_BURSTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
`ifdef M_AXI_READ_CHECK_EN
        S_READ,
`endif
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic          r_init_d;
    logic          r_start;
    logic          r_done;
    logic          r_error;
    logic [5:0]    r_b;
    logic [8:0]    r_k;
    logic          r_awvalid;
    logic [AW-1:0] r_awaddr;
    logic          r_wvalid;
    logic          r_wlast;
    logic [DW-1:0] r_wdata;
    logic          r_bready;
    logic          r_arvalid;
    logic [AW-1:0] r_araddr;
    logic          r_rready;
    logic [DW-1:0] r_exp;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_wr_end, w_rd_end;

    assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs   = r_wvalid & M_AXI_WREADY;
    assign w_b_hs   = r_bready & M_AXI_BVALID;
    assign w_ar_hs  = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs   = r_rready & M_AXI_RVALID;
    assign w_wr_end = (r_state == S_WRITE) && w_b_hs && (r_b == LAST_B);
`ifdef M_AXI_READ_CHECK_EN
    assign w_rd_end = (r_state == S_READ) && w_r_hs && M_AXI_RLAST && (r_b == LAST_B);
`else
    assign w_rd_end = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (r_start) w_state_next = S_WRITE;
`ifdef M_AXI_READ_CHECK_EN
            S_WRITE:        if (w_wr_end) w_state_next = S_READ;
            S_READ:         if (w_rd_end) w_state_next = S_DONE;
`else
            S_WRITE:        if (w_wr_end) w_state_next = S_DONE;
`endif
            default:        w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_init_d  <= 1'b0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_b       <= '0;
            r_k       <= '0;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wdata   <= '0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
            r_exp     <= '0;
        end else begin
            r_init_d <= INIT_AXI_TXN;
            r_start  <= INIT_AXI_TXN & ~r_init_d;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_start) begin
                        r_error   <= 1'b0;
                        r_done    <= 1'b0;
                        r_b       <= '0;
                        r_k       <= '0;
                        r_awvalid <= 1'b1;
                        r_awaddr  <= BASE;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= DW'(1);
                        r_wlast   <= (LAST_K == 9'd0);
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    // WDATA runs continuously across bursts, so no reload between them
                    if (w_w_hs) begin
                        r_wdata <= r_wdata + DW'(1);
                        r_k     <= r_k + 9'd1;
                        r_wlast <= (r_k + 9'd1 == LAST_K);
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                        end
                    end
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_k      <= '0;
                        if (M_AXI_BRESP[1]) r_error <= 1'b1;
                        if (r_b == LAST_B) begin
                            r_b <= '0;
`ifdef M_AXI_READ_CHECK_EN
                            r_arvalid <= 1'b1;
                            r_araddr  <= BASE;
                            r_exp     <= DW'(1);
`else
                            r_done    <= 1'b1;
`endif
                        end else begin
                            r_b       <= r_b + 6'd1;
                            r_awvalid <= 1'b1;
                            r_awaddr  <= r_awaddr + STRIDE;
                            r_wvalid  <= 1'b1;
                            r_wlast   <= (LAST_K == 9'd0);
                        end
                    end
                end
`ifdef M_AXI_READ_CHECK_EN
                S_READ: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_k   <= r_k + 9'd1;
                        r_exp <= r_exp + DW'(1);
                        if ((M_AXI_RDATA != r_exp) || M_AXI_RRESP[1] ||
                            (M_AXI_RLAST != (r_k == LAST_K)))
                            r_error <= 1'b1;
                        // RLAST closes the burst even if it arrives early; re-seed the pattern
                        if (M_AXI_RLAST) begin
                            r_rready <= 1'b0;
                            r_k      <= '0;
                            if (r_b == LAST_B) begin
                                r_done <= 1'b1;
                            end else begin
                                r_b       <= r_b + 6'd1;
                                r_arvalid <= 1'b1;
                                r_araddr  <= r_araddr + STRIDE;
                                r_exp     <= DW'((32'(r_b) + 32'd1) * 32'(C_M_AXI_BURST_LEN) + 32'd1);
                            end
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign TXN_DONE      = r_done;
    assign ERROR         = r_error;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = AXLEN;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WLAST   = r_wlast;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
`ifdef M_AXI_READ_CHECK_EN
    assign M_AXI_ARLEN   = AXLEN;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    logic w_unused;
    assign w_unused = ^{M_AXI_BRESP[0], M_AXI_RRESP[0], w_ar_hs};
`else
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b000;
    assign M_AXI_ARBURST = 2'b00;
    logic w_unused;
    assign w_unused = ^{M_AXI_BRESP[0], M_AXI_RRESP, M_AXI_RDATA, M_AXI_RLAST,
                        M_AXI_ARREADY, w_ar_hs, w_r_hs, w_rd_end, r_exp};
`endif

endmodule

// File: tb/tb_m_axi_burst_sequencer.sv
// tb/tb_m_axi_burst_sequencer.sv - scoreboard bench with an AXI4 memory slave model
`timescale 1ns/1ps
module tb_m_axi_burst_sequencer;

    localparam int          LEN  = 16;
    localparam int          NB   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst, init;
    logic        txn_done, error;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    m_axi_burst_sequencer dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .INIT_AXI_TXN(init),
        .TXN_DONE(txn_done), .ERROR(error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$], rq[$];
    logic [31:0] mem [logic [31:0]];

    bit stall_en = 0;
    int corrupt_b = -1, corrupt_k = -1, bresp_err_b = -1;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, wbeat, b_pend, rd_beat, rd_burst;
    bit ar_seen, rvalid_hold, done_chk;
    bit pend_aw, pend_w, pend_ar;
    logic [31:0] pend_aw_addr, pend_wdata, pend_ar_addr;

`ifdef M_AXI_READ_CHECK_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    // Slave: inputs set at each negedge, handshakes evaluated against the coming posedge
    initial begin
        logic [31:0] e;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        forever begin
            @(negedge clk);
            if (done_chk) check_eq("done_latency", txn_done, 1);
            done_chk = 0;
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                rq.delete(); b_pend = 0; wbeat = 0; rd_beat = 0; rvalid_hold = 0;
                pend_aw = 0; pend_w = 0; pend_ar = 0;
                continue;
            end
            if (pend_aw) begin
                check_eq("aw_hold", awvalid, 1);
                check_eq("aw_stable", awaddr, pend_aw_addr);
            end
            if (pend_w) begin
                check_eq("w_hold", wvalid, 1);
                check_eq("w_stable", wdata, pend_wdata);
            end
            if (pend_ar) begin
                check_eq("ar_hold", arvalid, 1);
                check_eq("ar_stable", araddr, pend_ar_addr);
            end
            if (arvalid) ar_seen = 1;

            awready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            wready  = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            arready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            bvalid  = (b_pend > 0);
            bresp   = (b_cnt == bresp_err_b) ? 2'b10 : 2'b00;
            if (rq.size() > 0) begin
                if (!rvalid_hold) rvalid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
                rdata = mem[rq[0] + 32'(rd_beat * 4)];
                if (rd_burst == corrupt_b && rd_beat == corrupt_k) rdata = 32'h0;
                rlast = (rd_beat == LEN - 1);
                rresp = 2'b00;
            end else begin
                rvalid = 0; rlast = 0;
            end

            if (awvalid && awready) begin
                if (exp_aw.size() == 0) check_eq("aw_extra", 1, 0);
                else begin
                    e = exp_aw.pop_front();
                    check_eq("aw_addr", awaddr, e);
                    check_eq("aw_len", awlen, LEN - 1);
                end
                aw_cnt++;
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) check_eq("w_extra", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    check_eq("wdata", wdata, e);
                end
                check_eq("wlast", wlast, (wbeat == LEN - 1));
                mem[awaddr + 32'(wbeat * 4)] = wdata;
                w_cnt++;
                if (wbeat == LEN - 1) begin wbeat = 0; b_pend++; end
                else wbeat++;
            end
            if (bvalid && bready) begin
                b_pend--; b_cnt++;
                if (b_cnt == NB && !READ_EN) begin
                    check_eq("done_early", txn_done, 0);
                    done_chk = 1;
                end
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) check_eq("ar_extra", 1, 0);
                else begin
                    e = exp_ar.pop_front();
                    check_eq("ar_addr", araddr, e);
                    check_eq("ar_len", arlen, LEN - 1);
                end
                rq.push_back(araddr);
                ar_cnt++;
            end
            if (rvalid && rready) begin
                r_cnt++;
                rvalid_hold = 0;
                if (rd_beat == LEN - 1) begin
                    void'(rq.pop_front());
                    rd_beat = 0; rd_burst++;
                    if (rd_burst == NB) begin
                        check_eq("done_early", txn_done, 0);
                        done_chk = 1;
                    end
                end else rd_beat++;
            end else rvalid_hold = rvalid;

            pend_aw = awvalid && !awready; pend_aw_addr = awaddr;
            pend_w  = wvalid && !wready;   pend_wdata   = wdata;
            pend_ar = arvalid && !arready; pend_ar_addr = araddr;
        end
    end

    task automatic start_txn();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rd_burst = 0; ar_seen = 0;
        for (int b = 0; b < NB; b++) begin
            exp_aw.push_back(BASE + 32'(b * LEN * 4));
            if (READ_EN) exp_ar.push_back(BASE + 32'(b * LEN * 4));
            for (int k = 0; k < LEN; k++) exp_w.push_back(32'(b * LEN + k + 1));
        end
        init = 1;
        @(negedge clk);
        check_eq("start_lat_n1", awvalid, 0);
        @(negedge clk);
        check_eq("start_lat_n2", awvalid, 1);
        check_eq("start_err_clr", error, 0);
        check_eq("start_done_clr", txn_done, 0);
        init = 0;
    endtask

    task automatic run_txn(input logic exp_err);
        int cyc;
        start_txn();
        cyc = 0;
        while (!txn_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("done_timeout", txn_done, 1);
        check_eq("error_flag", error, exp_err);
        check_eq("aw_count", aw_cnt, NB);
        check_eq("w_count", w_cnt, NB * LEN);
        check_eq("w_left", exp_w.size(), 0);
        if (READ_EN) begin
            check_eq("ar_count", ar_cnt, NB);
            check_eq("r_count", r_cnt, NB * LEN);
        end else begin
            check_eq("no_ar", ar_seen, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst = 1; init = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_wlast", wlast, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_done", txn_done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_awaddr", awaddr, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_araddr", araddr, 0);
        check_eq("awsize", awsize, 3'b010);
        check_eq("awburst", awburst, 2'b01);
        check_eq("wstrb", wstrb, 4'hF);
        check_eq("arsize", arsize, READ_EN ? 3'b010 : 3'b000);
        check_eq("arburst", arburst, READ_EN ? 2'b01 : 2'b00);
        rst = 0;
        repeat (2) @(negedge clk);

        run_txn(0);
        check_eq("last_beat_mem", mem[BASE + 32'hFC], 32'h40);

        stall_en = 1;
        run_txn(0);
        stall_en = 0;

        if (READ_EN) begin
            corrupt_b = 2; corrupt_k = 5;
            run_txn(1);
            corrupt_b = -1; corrupt_k = -1;
        end

        bresp_err_b = 0;
        run_txn(1);
        bresp_err_b = -1;
        run_txn(0);

        start_txn();
        cyc = 0;
        while (w_cnt < LEN + 7 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_reach_b1k7", (w_cnt >= LEN + 7), 1);
        rst = 1;
        @(negedge clk);
        check_eq("mid_rst_awvalid", awvalid, 0);
        check_eq("mid_rst_wvalid", wvalid, 0);
        check_eq("mid_rst_bready", bready, 0);
        check_eq("mid_rst_wlast", wlast, 0);
        check_eq("mid_rst_awaddr", awaddr, 0);
        check_eq("mid_rst_wdata", wdata, 0);
        check_eq("mid_rst_done", txn_done, 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        run_txn(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
